mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Two-requester arbiter sharing a single native memory port (valid/ready, instr, addr, wdata, wstrb, rdata) between the minrv32 core (requester 0) and an auxiliary master (requester 1, e.g. debug loader or DMA).
- Round-robin grant, held for the whole transaction; back-to-back handover with no idle cycle.
- Bus timeout watchdog: completes a hung access with a forced ready and sets a sticky error.
- Sits between the core/aux masters and the memory or formal memory model.

Parameters:
- TIMEOUT_CYCLES, 1024, cycles without mem_ready before forced completion; 0 disables the watchdog.
- TO_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_valid  in  1  core request.
- m0_instr  in  1  core fetch flag.
- m0_addr  in  32  core address.
- m0_wdata  in  32  core write data.
- m0_wstrb  in  4  core byte strobes; 0 = read.
- m0_ready  out  1  core completion pulse.
- m0_rdata  out  32  core read data.
- m1_valid/m1_instr/m1_addr/m1_wdata/m1_wstrb/m1_ready/m1_rdata  same widths and meanings, aux master.
- mem_valid  out  1  shared port request.
- mem_instr  out  1  muxed fetch flag.
- mem_addr  out  32  muxed address.
- mem_wdata  out  32  muxed write data.
- mem_wstrb  out  4  muxed strobes.
- mem_ready  in  1  memory completion.
- mem_rdata  in  32  memory read data.
- grant  out  1  current/last owner (0 = core).
- bus_err  out  1  sticky timeout flag.
- err_clear  in  1  synchronous clear of bus_err.

Behaviour:
- States: IDLE, BUSY0, BUSY1. Registered state, last-grant pointer lp, timeout counter tc.
- Reset (asynchronous, any state, including mid-transaction):
  - state = IDLE, lp = 1 (so m0 wins the first tie), tc = 0, bus_err = 0.
  - mem_valid = 0, m0_ready = m1_ready = 0, grant = 0.
- IDLE:
  - mem_valid = 0.
  - If exactly one mx_valid is high, go to BUSYx.
  - If both are high, go to BUSY(~lp).
  - Arbitration latency: 1 cycle from request to mem_valid.
- BUSYx:
  - mem_valid = 1. mem_instr/addr/wdata/wstrb = mx_* (combinational mux; masters hold fields stable while valid).
  - grant = x; lp <= x on entry.
  - mx_ready = mem_ready (combinational); the other ready = 0.
  - Both mx_rdata = mem_rdata at all times; only the ready qualifies them.
- Completion (mem_ready = 1, or timeout, in BUSYx):
  - If the other master's valid is high that cycle, go to BUSY(other) next cycle.
  - Otherwise go to IDLE.
  - Never re-grant the same master directly: its valid is still the old request during the ready cycle.
- Timeout (TIMEOUT_CYCLES > 0):
  - tc clears on entry to BUSYx and increments each BUSY cycle with mem_ready = 0.
  - When tc == TIMEOUT_CYCLES-1 and mem_ready = 0:
    - mx_ready = 1 for that cycle, mx_rdata forced to 32'h0.
    - bus_err <= 1.
    - Completion rules above apply.
  - A late mem_ready after a forced completion is ignored by the requesters. Memory is required to tolerate mem_valid deassertion.
- bus_err: sticky. err_clear clears it. err_clear and a timeout in the same cycle leave bus_err = 1 (set wins).
- mx_valid deasserted mid-BUSY is a protocol violation. The arbiter stays in BUSYx until completion; no assertion is raised in RTL.
- mem_valid never drops while mem_ready is low, except on timeout or reset.
- ready is never asserted to a master whose valid is low.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, BUSY0, BUSY1}.
  - MEM_AW = 32, MEM_DW = 32, MEM_SW = 4.
  - TIMEOUT_RDATA = 32'h0.
- Sub-module mem_arb_timeout: counter and compare. Inputs start, busy, mem_ready; output expire. Reused by future bus bridges.

Test Plan:
- Single core read: m0_valid with addr 0x100, mem_ready on the 3rd BUSY cycle, rdata 0xDEADBEEF -> mem_valid 1 cycle after request, m0_ready pulse with m0_rdata 0xDEADBEEF, m1_ready stays 0, return to IDLE.
- Simultaneous requests after reset: m0 and m1 both valid -> m0 granted first; on m0 completion, BUSY1 the very next cycle with mem_addr = m1_addr; grant sequence 0,1.
- Fairness under saturation: both masters re-request continuously for 8 transactions -> grants strictly alternate 0,1,0,1,...; no idle cycle between transactions.
- Timeout: TIMEOUT_CYCLES = 4, m1 write with wstrb 4'hF and mem_ready held low -> m1_ready pulses on the 4th BUSY cycle, m1_rdata = 0, bus_err = 1 and stays 1; err_clear pulse -> bus_err = 0.
- Reset mid-transaction: assert reset during BUSY0 -> mem_valid, m0_ready, bus_err drop immediately (asynchronously); after release, a pending m1 request is served first only if m0 is idle.
- Timeout disabled: TIMEOUT_CYCLES = 0, mem_ready withheld 5000 cycles -> no forced ready, bus_err stays 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the memory-port arbiter.
//   arb_state_t   - arbiter FSM states (idle, core owns port, aux owns port)
//   MEM_AW/DW/SW  - native memory port address, data and strobe widths
//   TIMEOUT_RDATA - read data returned to a master on a forced completion
package mem_arb_pkg;

  localparam int unsigned MEM_AW = 32;
  localparam int unsigned MEM_DW = 32;
  localparam int unsigned MEM_SW = 4;

  localparam logic [MEM_DW-1:0] TIMEOUT_RDATA = 32'h0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: native memory port bundle (valid/ready handshake).
//   valid, instr, addr, wdata, wstrb - request, driven by the master side
//   ready, rdata                     - response, driven by the slave side
// Modports:
//   master - the requesting side (core, aux master, or arbiter towards memory)
//   slave  - the responding side (memory, or arbiter towards a requester)
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  logic              valid;
  logic              instr;
  logic [MEM_AW-1:0] addr;
  logic [MEM_DW-1:0] wdata;
  logic [MEM_SW-1:0] wstrb;
  logic              ready;
  logic [MEM_DW-1:0] rdata;

  modport master (
    output valid, instr, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  valid, instr, addr, wdata, wstrb,
    output ready, rdata
  );

endinterface

// File: rtl/mem_port_arbiter_timeout.sv
// mem_arb_timeout: bus watchdog counter.
//   clk, rst   - clock, asynchronous active-high reset
//   start      - a new transaction begins next cycle (clears the counter)
//   busy       - a transaction is in progress this cycle
//   mem_ready  - memory completed the access this cycle
//   expire     - this cycle is the last allowed cycle without mem_ready
// TIMEOUT_CYCLES = 0 removes the counter and expire stays low.
module mem_arb_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic busy,
  input  logic mem_ready,
  output logic expire
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, start, busy, mem_ready};
      assign expire = 1'b0;
    end else begin : g_on
      localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

      logic [TO_W-1:0] tc;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          tc <= '0;
        end else if (start) begin
          tc <= '0;
        end else if (busy && !mem_ready) begin
          tc <= tc + 1'b1;
        end
      end

      assign expire = busy && !mem_ready && (tc == LAST);
    end
  endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one native memory port
// between the core (m0) and an auxiliary master (m1), with a bus watchdog.
//   clk, reset - clock, asynchronous active-high reset
//   m0, m1     - requester ports (arbiter is the responding side)
//   mem        - shared memory port (arbiter is the requesting side)
//   grant      - current / last owner of the port (0 = core)
//   bus_err    - sticky flag, set when the watchdog forces a completion
//   err_clear  - synchronous clear of bus_err (a same-cycle timeout wins)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  mem_port_arbiter_if.slave         m0,
  mem_port_arbiter_if.slave         m1,
  mem_port_arbiter_if.master        mem,
  output logic                      grant,
  output logic                      bus_err,
  input  logic                      err_clear
);

  arb_state_t state;
  arb_state_t state_nx;
  logic       lp;
  logic       busy;
  logic       expire;
  logic       done;
  logic       start;

  assign busy = (state != IDLE);
  assign done = busy && (mem.ready || expire);
  // Entry into a BUSY state, either from IDLE or as a back-to-back handover.
  assign start = (state_nx != IDLE) && ((state == IDLE) || done);

  mem_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst       (reset),
    .start     (start),
    .busy      (busy),
    .mem_ready (mem.ready),
    .expire    (expire)
  );

  // lp starts at 1 so the core wins the first tie; grant reports 0 out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      lp      <= 1'b1;
      grant   <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (start) begin
        lp    <= (state_nx == BUSY1);
        grant <= (state_nx == BUSY1);
      end
      if (expire) begin
        bus_err <= 1'b1;
      end else if (err_clear) begin
        bus_err <= 1'b0;
      end
    end
  end

  // On completion the owner's valid still shows the finished request, so
  // control only ever passes to the other master or back to IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (m0.valid && m1.valid) begin
          state_nx = lp ? BUSY0 : BUSY1;
        end else if (m0.valid) begin
          state_nx = BUSY0;
        end else if (m1.valid) begin
          state_nx = BUSY1;
        end
      end
      BUSY0: begin
        if (done) begin
          state_nx = m1.valid ? BUSY1 : IDLE;
        end
      end
      BUSY1: begin
        if (done) begin
          state_nx = m0.valid ? BUSY0 : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem.valid = busy;
    mem.instr = m0.instr;
    mem.addr  = m0.addr;
    mem.wdata = m0.wdata;
    mem.wstrb = m0.wstrb;
    if (state == BUSY1) begin
      mem.instr = m1.instr;
      mem.addr  = m1.addr;
      mem.wdata = m1.wdata;
      mem.wstrb = m1.wstrb;
    end

    m0.ready = (state == BUSY0) && (mem.ready || expire);
    m1.ready = (state == BUSY1) && (mem.ready || expire);

    m0.rdata = ((state == BUSY0) && expire) ? TIMEOUT_RDATA : mem.rdata;
    m1.rdata = ((state == BUSY1) && expire) ? TIMEOUT_RDATA : mem.rdata;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: self-checking bench for mem_port_arbiter.
// Main instance uses a 4-cycle watchdog; a second instance has the watchdog
// disabled and sits on a never-answered core request for the whole run.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  logic rst_b;
  logic err_clear;
  logic err_clear_b;
  logic grant, bus_err, b_grant, b_bus_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if m0_if ();
  mem_port_arbiter_if m1_if ();
  mem_port_arbiter_if mem_if ();
  mem_port_arbiter_if b_m0_if ();
  mem_port_arbiter_if b_m1_if ();
  mem_port_arbiter_if b_mem_if ();

  mem_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(rst), .m0(m0_if), .m1(m1_if), .mem(mem_if),
    .grant(grant), .bus_err(bus_err), .err_clear(err_clear)
  );

  mem_port_arbiter #(.TIMEOUT_CYCLES(0)) dut_nto (
    .clk(clk), .reset(rst_b), .m0(b_m0_if), .m1(b_m1_if), .mem(b_mem_if),
    .grant(b_grant), .bus_err(b_bus_err), .err_clear(err_clear_b)
  );

  // Stimulus state for the main instance.
  logic        req_valid [2];
  logic        req_instr [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wstrb [2];
  logic        mem_rdy;
  logic [31:0] mem_rd;

  // Reference model: who owns the port, how long it has waited, last winner.
  int   owner;
  int   last_pick;
  int   grant_m;
  int   age;
  logic err_m;
  logic dn_m, to_m;
  logic done_last [2];

  // Disabled-watchdog observation.
  int b_cycles = 0;
  int b_ready_cnt = 0;
  int b_err_cnt = 0;

  always @(negedge clk) begin
    if (!rst_b) begin
      b_cycles++;
      if (b_m0_if.ready === 1'b1) b_ready_cnt++;
      if (b_bus_err === 1'b1) b_err_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    m0_if.valid = req_valid[0]; m0_if.instr = req_instr[0]; m0_if.addr = req_addr[0];
    m0_if.wdata = req_wdata[0]; m0_if.wstrb = req_wstrb[0];
    m1_if.valid = req_valid[1]; m1_if.instr = req_instr[1]; m1_if.addr = req_addr[1];
    m1_if.wdata = req_wdata[1]; m1_if.wstrb = req_wstrb[1];
    mem_if.ready = mem_rdy;
    mem_if.rdata = mem_rd;
  endtask

  task automatic new_req(input int i);
    req_valid[i] = 1'b1;
    req_instr[i] = 1'($urandom_range(0, 1));
    req_addr[i]  = $urandom;
    req_wdata[i] = $urandom;
    req_wstrb[i] = 4'($urandom_range(0, 15));
  endtask

  task automatic model_reset();
    owner = -1; last_pick = 1; grant_m = 0; age = 0; err_m = 1'b0;
    dn_m = 1'b0; to_m = 1'b0; done_last[0] = 1'b0; done_last[1] = 1'b0;
  endtask

  // Apply inputs, let them settle, compare every output with the model.
  task automatic settle_check();
    logic [31:0] e_rd0, e_rd1;
    drive();
    #2;
    to_m = (TO > 0) && (owner >= 0) && (age == TO - 1) && !mem_rdy;
    dn_m = (owner >= 0) && (mem_rdy || to_m);
    chk("mem_valid", 32'(mem_if.valid), 32'(owner >= 0));
    if (owner >= 0) begin
      chk("mem_addr",  mem_if.addr,         req_addr[owner]);
      chk("mem_wdata", mem_if.wdata,        req_wdata[owner]);
      chk("mem_wstrb", 32'(mem_if.wstrb),   32'(req_wstrb[owner]));
      chk("mem_instr", 32'(mem_if.instr),   32'(req_instr[owner]));
    end
    chk("m0_ready", 32'(m0_if.ready), 32'(dn_m && owner == 0));
    chk("m1_ready", 32'(m1_if.ready), 32'(dn_m && owner == 1));
    e_rd0 = (owner == 0 && to_m) ? 32'h0 : mem_rd;
    e_rd1 = (owner == 1 && to_m) ? 32'h0 : mem_rd;
    chk("m0_rdata", m0_if.rdata, e_rd0);
    chk("m1_rdata", m1_if.rdata, e_rd1);
    chk("grant",    32'(grant),   32'(grant_m));
    chk("bus_err",  32'(bus_err), 32'(err_m));
  endtask

  // Move the model to the next cycle and step the clock.
  task automatic advance();
    done_last[0] = dn_m && owner == 0;
    done_last[1] = dn_m && owner == 1;
    if (owner < 0) begin
      if (req_valid[0] && req_valid[1]) owner = 1 - last_pick;
      else if (req_valid[0])            owner = 0;
      else if (req_valid[1])            owner = 1;
      if (owner >= 0) begin
        last_pick = owner; grant_m = owner; age = 0;
      end
    end else if (dn_m) begin
      if (req_valid[1 - owner]) begin
        owner = 1 - owner; last_pick = owner; grant_m = owner; age = 0;
      end else begin
        owner = -1;
      end
    end else begin
      age++;
    end
    if (to_m) err_m = 1'b1;
    else if (err_clear) err_m = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    settle_check();
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_instr[i] = 1'b0; req_addr[i] = '0;
      req_wdata[i] = '0; req_wstrb[i] = '0;
    end
    mem_rdy = 1'b0; mem_rd = '0; err_clear = 1'b0;
    drive();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int prev, n, exp_g;
    int served [2];

    rst_b = 1'b1;
    err_clear_b = 1'b0;
    b_m0_if.valid = 1'b1; b_m0_if.instr = 1'b0; b_m0_if.addr = 32'h200;
    b_m0_if.wdata = 32'h0; b_m0_if.wstrb = 4'h0;
    b_m1_if.valid = 1'b0; b_m1_if.instr = 1'b0; b_m1_if.addr = '0;
    b_m1_if.wdata = '0; b_m1_if.wstrb = '0;
    b_mem_if.ready = 1'b0; b_mem_if.rdata = 32'h0;

    do_reset();
    rst_b = 1'b0;

    // Reset values.
    settle_check();
    chk("rst_mem_valid", 32'(mem_if.valid), 32'h0);
    chk("rst_grant",     32'(grant),        32'h0);
    chk("rst_bus_err",   32'(bus_err),      32'h0);
    advance();

    // Single core read, memory answers on the 3rd BUSY cycle.
    req_valid[0] = 1'b1; req_addr[0] = 32'h100; req_wstrb[0] = 4'h0;
    req_instr[0] = 1'b0; req_wdata[0] = 32'h0;
    settle_check();
    chk("t1_idle_valid", 32'(mem_if.valid), 32'h0);
    advance();
    settle_check();
    chk("t1_latency_valid", 32'(mem_if.valid), 32'h1);
    chk("t1_addr", mem_if.addr, 32'h100);
    advance();
    tick();
    mem_rdy = 1'b1; mem_rd = 32'hDEADBEEF;
    settle_check();
    chk("t1_m0_ready", 32'(m0_if.ready), 32'h1);
    chk("t1_m0_rdata", m0_if.rdata, 32'hDEADBEEF);
    chk("t1_m1_ready", 32'(m1_if.ready), 32'h0);
    advance();
    req_valid[0] = 1'b0; mem_rdy = 1'b0;
    settle_check();
    chk("t1_back_idle", 32'(mem_if.valid), 32'h0);
    advance();

    // Simultaneous requests after reset: core first, aux directly after.
    do_reset();
    new_req(0); new_req(1);
    req_addr[0] = 32'h1000; req_addr[1] = 32'h2000;
    tick();
    mem_rdy = 1'b1;
    settle_check();
    chk("t2_first_grant", 32'(grant), 32'h0);
    chk("t2_first_addr", mem_if.addr, 32'h1000);
    advance();
    req_valid[0] = 1'b0;
    settle_check();
    chk("t2_handover_valid", 32'(mem_if.valid), 32'h1);
    chk("t2_second_grant", 32'(grant), 32'h1);
    chk("t2_second_addr", mem_if.addr, 32'h2000);
    advance();
    req_valid[1] = 1'b0; mem_rdy = 1'b0;
    tick();

    // Saturation: both masters always requesting, grants must alternate.
    do_reset();
    new_req(0); new_req(1);
    tick();
    prev = -1; n = 0;
    for (int c = 0; c < 200 && n < 8; c++) begin
      for (int i = 0; i < 2; i++) if (done_last[i]) new_req(i);
      mem_rdy = 1'($urandom_range(0, 1)); mem_rd = $urandom;
      settle_check();
      chk("t3_no_idle", 32'(mem_if.valid), 32'h1);
      if (dn_m) begin
        exp_g = (prev < 0) ? 0 : 1 - prev;
        chk("t3_alternate", 32'(grant), 32'(exp_g));
        prev = exp_g;
        n++;
      end
      advance();
    end
    chk("t3_txn_count", 32'(n), 32'd8);

    // Watchdog: aux write with memory silent.
    do_reset();
    req_valid[1] = 1'b1; req_addr[1] = 32'h3000; req_wdata[1] = 32'hCAFEF00D;
    req_wstrb[1] = 4'hF; req_instr[1] = 1'b0;
    mem_rd = 32'h12345678;
    tick();
    for (int c = 0; c < TO - 1; c++) begin
      settle_check();
      chk("t4_no_early_ready", 32'(m1_if.ready), 32'h0);
      advance();
    end
    settle_check();
    chk("t4_forced_ready", 32'(m1_if.ready), 32'h1);
    chk("t4_forced_rdata", m1_if.rdata, 32'h0);
    advance();
    req_valid[1] = 1'b0;
    settle_check();
    chk("t4_err_set", 32'(bus_err), 32'h1);
    advance();
    repeat (3) tick();
    settle_check();
    chk("t4_err_sticky", 32'(bus_err), 32'h1);
    advance();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    settle_check();
    chk("t4_err_cleared", 32'(bus_err), 32'h0);
    advance();

    // Second timeout with err_clear held on the expiring cycle: set wins.
    new_req(1);
    tick();
    repeat (TO - 1) tick();
    err_clear = 1'b1;
    settle_check();
    chk("t4b_forced_ready", 32'(m1_if.ready), 32'h1);
    advance();
    err_clear = 1'b0; req_valid[1] = 1'b0;
    settle_check();
    chk("t4b_set_wins", 32'(bus_err), 32'h1);
    advance();

    // Reset in the middle of a core transaction (bus_err still set).
    new_req(0);
    tick();
    mem_rdy = 1'b1;
    settle_check();
    chk("t5_pre_ready", 32'(m0_if.ready), 32'h1);
    rst = 1'b1;
    #1;
    chk("t5_async_valid", 32'(mem_if.valid), 32'h0);
    chk("t5_async_ready", 32'(m0_if.ready), 32'h0);
    chk("t5_async_err",   32'(bus_err),      32'h0);
    chk("t5_async_grant", 32'(grant),        32'h0);
    model_reset();
    mem_rdy = 1'b0; req_valid[0] = 1'b0;
    new_req(1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    settle_check();
    chk("t5_m1_served", 32'(grant), 32'h1);
    chk("t5_m1_addr", mem_if.addr, req_addr[1]);
    advance();
    mem_rdy = 1'b1;
    tick();
    req_valid[1] = 1'b0; mem_rdy = 1'b0;
    tick();

    // Random traffic against the model.
    do_reset();
    served[0] = 0; served[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (done_last[i]) served[i]++;
        if (req_valid[i] && done_last[i]) begin
          if ($urandom_range(0, 1) == 1) new_req(i);
          else req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          new_req(i);
        end
      end
      mem_rdy = (owner >= 0) && ($urandom_range(0, 1) == 1);
      mem_rd = $urandom;
      err_clear = ($urandom_range(0, 7) == 0);
      tick();
    end
    chk("rand_m0_served", 32'(served[0] > 50), 32'h1);
    chk("rand_m1_served", 32'(served[1] > 50), 32'h1);

    // Let the disabled-watchdog instance sit through its 5000-cycle window.
    for (int i = 0; i < 2; i++) req_valid[i] = 1'b0;
    mem_rdy = 1'b0; err_clear = 1'b0;
    tick();
    for (int c = 0; c < 6000 && b_cycles < 5000; c++) tick();
    chk("nto_window",    32'(b_cycles >= 5000), 32'h1);
    chk("nto_no_ready",  32'(b_ready_cnt),      32'h0);
    chk("nto_no_err",    32'(b_err_cnt),        32'h0);
    chk("nto_still_valid", 32'(b_mem_if.valid), 32'h1);
    chk("nto_grant",     32'(b_grant),          32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
